// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: bus widths, requester IDs and the response tag.
package mem_port_arbiter_pkg;

    localparam int SIZE_ADDR    = 16;
    localparam int SIZE_DATA    = 32;
    localparam int SIZE_ARB_TAG = 3;

    typedef enum logic [1:0] {
        ARB_NONE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_MA   = 2'b10,
        ARB_DBG  = 2'b11
    } arb_owner_e;

    typedef struct packed {
        arb_owner_e owner;
        logic       is_read;
    } arb_tag_t;

endpackage

// File: rtl/mem_rsp_pipe.sv
// Per-port response tag delay line: carries {owner, is_read} from grant to read-data return.
module mem_rsp_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic     iw_clk,
    input  logic     iw_rst,
    input  arb_tag_t load_tag,
    output arb_tag_t tail_tag
);

    arb_tag_t stage [RD_LAT];

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= load_tag;
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tail_tag = stage[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares two memory ports between IF, MA and DBG; owns the port phase bit and routes read data back.
// Handshake: a requester raises req with its fields stable; gnt (same cycle) accepts it, otherwise it holds.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int RD_LAT       = 1,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_if_req,
    input  logic [SIZE_ADDR-1:0] iw_if_addr,
    output logic                 ow_if_gnt,
    output logic                 ow_if_rvalid,
    output logic [SIZE_DATA-1:0] ow_if_rdata,
    input  logic                 iw_ma_req,
    input  logic                 iw_ma_we,
    input  logic [SIZE_ADDR-1:0] iw_ma_addr,
    input  logic [SIZE_DATA-1:0] iw_ma_wdata,
    output logic                 ow_ma_gnt,
    output logic                 ow_ma_rvalid,
    output logic [SIZE_DATA-1:0] ow_ma_rdata,
    input  logic                 iw_dbg_req,
    input  logic                 iw_dbg_we,
    input  logic [SIZE_ADDR-1:0] iw_dbg_addr,
    input  logic [SIZE_DATA-1:0] iw_dbg_wdata,
    output logic                 ow_dbg_gnt,
    output logic                 ow_dbg_rvalid,
    output logic [SIZE_DATA-1:0] ow_dbg_rdata,
    output logic                 ow_mp,
    output logic [CNT_W-1:0]     ow_starve_cnt,
    output logic [1:0]           ow_mem_en,
    output logic [1:0]           ow_mem_we,
    output logic [SIZE_ADDR-1:0] ow_mem_addr0,
    output logic [SIZE_ADDR-1:0] ow_mem_addr1,
    output logic [SIZE_DATA-1:0] ow_mem_wdata0,
    output logic [SIZE_DATA-1:0] ow_mem_wdata1,
    input  logic [SIZE_DATA-1:0] iw_mem_rdata0,
    input  logic [SIZE_DATA-1:0] iw_mem_rdata1
);

    logic             mp;
    logic [CNT_W-1:0] starve_cnt;
    logic             force_dbg;
    arb_owner_e       pm_own, po_own, own0, own1;
    arb_tag_t         load0, load1, tail0, tail1;

    function automatic logic owner_we(arb_owner_e own, logic ma_we, logic dbg_we);
        case (own)
            ARB_MA:  return ma_we;
            ARB_DBG: return dbg_we;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [SIZE_ADDR-1:0] owner_addr(arb_owner_e own, logic [SIZE_ADDR-1:0] if_a,
                                                        logic [SIZE_ADDR-1:0] ma_a,
                                                        logic [SIZE_ADDR-1:0] dbg_a);
        case (own)
            ARB_IF:  return if_a;
            ARB_MA:  return ma_a;
            ARB_DBG: return dbg_a;
            default: return '0;
        endcase
    endfunction

    function automatic logic [SIZE_DATA-1:0] owner_wdata(arb_owner_e own, logic [SIZE_DATA-1:0] ma_d,
                                                         logic [SIZE_DATA-1:0] dbg_d);
        case (own)
            ARB_MA:  return ma_d;
            ARB_DBG: return dbg_d;
            default: return '0;
        endcase
    endfunction

    // po is decided first so DBG lands there when both ports are free.
    always_comb begin
        pm_own    = ARB_NONE;
        po_own    = ARB_NONE;
        force_dbg = (starve_cnt == CNT_W'(STARVE_LIMIT)) && iw_dbg_req;
        if (!iw_rst) begin
            if (iw_if_req && !force_dbg) po_own = ARB_IF;
            else if (iw_dbg_req)         po_own = ARB_DBG;
            if (iw_ma_req)                               pm_own = ARB_MA;
            else if (iw_dbg_req && po_own != ARB_DBG)    pm_own = ARB_DBG;
            if (pm_own != ARB_NONE && po_own != ARB_NONE &&
                owner_addr(pm_own, iw_if_addr, iw_ma_addr, iw_dbg_addr) ==
                owner_addr(po_own, iw_if_addr, iw_ma_addr, iw_dbg_addr)) begin
                if (owner_we(pm_own, iw_ma_we, iw_dbg_we))      po_own = ARB_NONE;
                else if (owner_we(po_own, iw_ma_we, iw_dbg_we)) pm_own = ARB_NONE;
            end
        end
    end

    assign own0 = mp ? pm_own : po_own;
    assign own1 = mp ? po_own : pm_own;

    assign ow_if_gnt  = (po_own == ARB_IF);
    assign ow_ma_gnt  = (pm_own == ARB_MA);
    assign ow_dbg_gnt = (pm_own == ARB_DBG) || (po_own == ARB_DBG);

    assign ow_mem_en     = {own1 != ARB_NONE, own0 != ARB_NONE};
    assign ow_mem_we     = {owner_we(own1, iw_ma_we, iw_dbg_we), owner_we(own0, iw_ma_we, iw_dbg_we)};
    assign ow_mem_addr0  = owner_addr(own0, iw_if_addr, iw_ma_addr, iw_dbg_addr);
    assign ow_mem_addr1  = owner_addr(own1, iw_if_addr, iw_ma_addr, iw_dbg_addr);
    assign ow_mem_wdata0 = owner_wdata(own0, iw_ma_wdata, iw_dbg_wdata);
    assign ow_mem_wdata1 = owner_wdata(own1, iw_ma_wdata, iw_dbg_wdata);

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            mp         <= 1'b0;
            starve_cnt <= '0;
        end else begin
            mp <= ~mp;
            if (!iw_dbg_req || ow_dbg_gnt)                starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign ow_mp         = mp;
    assign ow_starve_cnt = starve_cnt;

    always_comb begin
        load0.owner   = own0;
        load0.is_read = (own0 != ARB_NONE) && !ow_mem_we[0];
        load1.owner   = own1;
        load1.is_read = (own1 != ARB_NONE) && !ow_mem_we[1];
    end

    mem_rsp_pipe #(.RD_LAT(RD_LAT)) u_pipe0 (.iw_clk(iw_clk), .iw_rst(iw_rst), .load_tag(load0), .tail_tag(tail0));
    mem_rsp_pipe #(.RD_LAT(RD_LAT)) u_pipe1 (.iw_clk(iw_clk), .iw_rst(iw_rst), .load_tag(load1), .tail_tag(tail1));

    // A requester owns at most one tail per cycle, so the two hits are exclusive.
    always_comb begin
        ow_if_rvalid  = 1'b0;
        ow_ma_rvalid  = 1'b0;
        ow_dbg_rvalid = 1'b0;
        ow_if_rdata   = '0;
        ow_ma_rdata   = '0;
        ow_dbg_rdata  = '0;
        if (tail0.is_read) begin
            case (tail0.owner)
                ARB_IF:  begin ow_if_rvalid  = 1'b1; ow_if_rdata  = iw_mem_rdata0; end
                ARB_MA:  begin ow_ma_rvalid  = 1'b1; ow_ma_rdata  = iw_mem_rdata0; end
                ARB_DBG: begin ow_dbg_rvalid = 1'b1; ow_dbg_rdata = iw_mem_rdata0; end
                default: ;
            endcase
        end
        if (tail1.is_read) begin
            case (tail1.owner)
                ARB_IF:  begin ow_if_rvalid  = 1'b1; ow_if_rdata  = iw_mem_rdata1; end
                ARB_MA:  begin ow_ma_rvalid  = 1'b1; ow_ma_rdata  = iw_mem_rdata1; end
                ARB_DBG: begin ow_dbg_rvalid = 1'b1; ow_dbg_rdata = iw_mem_rdata1; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: phase toggling, routing, collisions, starvation and reset drop.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam logic [SIZE_DATA-1:0] RD0 = 32'hA0A0_0000;
    localparam logic [SIZE_DATA-1:0] RD1 = 32'hB1B1_0001;

    logic                 iw_clk = 1'b0;
    logic                 iw_rst = 1'b1;
    logic                 if_req = 1'b0, ma_req = 1'b0, ma_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [SIZE_ADDR-1:0] if_addr = '0, ma_addr = '0, dbg_addr = '0;
    logic [SIZE_DATA-1:0] ma_wdata = '0, dbg_wdata = '0;
    logic                 if_gnt, if_rvalid, ma_gnt, ma_rvalid, dbg_gnt, dbg_rvalid, mp;
    logic [SIZE_DATA-1:0] if_rdata, ma_rdata, dbg_rdata;
    logic [3:0]           starve_cnt;
    logic [1:0]           mem_en, mem_we;
    logic [SIZE_ADDR-1:0] mem_addr0, mem_addr1;
    logic [SIZE_DATA-1:0] mem_wdata0, mem_wdata1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        exp_mp   = 1'b0;
    logic [31:0] exp_q[$];

    mem_port_arbiter #(.STARVE_LIMIT(8), .RD_LAT(1)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_if_req(if_req), .iw_if_addr(if_addr),
        .ow_if_gnt(if_gnt), .ow_if_rvalid(if_rvalid), .ow_if_rdata(if_rdata),
        .iw_ma_req(ma_req), .iw_ma_we(ma_we), .iw_ma_addr(ma_addr), .iw_ma_wdata(ma_wdata),
        .ow_ma_gnt(ma_gnt), .ow_ma_rvalid(ma_rvalid), .ow_ma_rdata(ma_rdata),
        .iw_dbg_req(dbg_req), .iw_dbg_we(dbg_we), .iw_dbg_addr(dbg_addr), .iw_dbg_wdata(dbg_wdata),
        .ow_dbg_gnt(dbg_gnt), .ow_dbg_rvalid(dbg_rvalid), .ow_dbg_rdata(dbg_rdata),
        .ow_mp(mp), .ow_starve_cnt(starve_cnt),
        .ow_mem_en(mem_en), .ow_mem_we(mem_we),
        .ow_mem_addr0(mem_addr0), .ow_mem_addr1(mem_addr1),
        .ow_mem_wdata0(mem_wdata0), .ow_mem_wdata1(mem_wdata1),
        .iw_mem_rdata0(RD0), .iw_mem_rdata1(RD1)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iw_clk);
        if (!iw_rst) exp_mp = ~exp_mp;
        #1;
    endtask

    task automatic clear_reqs();
        if_req = 1'b0; ma_req = 1'b0; ma_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    function automatic logic [31:0] port_data(input logic port);
        return port ? RD1 : RD0;
    endfunction

    task automatic check_rsp(input string tag, input logic vld, input logic [31:0] data);
        check_val({tag, "_rvalid"}, 32'(vld), 32'd1);
        if (exp_q.size() == 0) check_val({tag, "_q_empty"}, 32'd1, 32'd0);
        else                   check_val({tag, "_rdata"}, data, exp_q.pop_front());
    endtask

    initial begin
        clear_reqs();
        tick(); tick();
        check_val("rst_mp", 32'(mp), 32'd0);
        check_val("rst_en", 32'(mem_en), 32'd0);
        check_val("rst_cnt", 32'(starve_cnt), 32'd0);
        check_val("rst_rvalid", 32'({if_rvalid, ma_rvalid, dbg_rvalid}), 32'd0);

        // 1: idle phase toggling
        iw_rst = 1'b0; exp_mp = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_val("idle_mp", 32'(mp), 32'(exp_mp));
            check_val("idle_gnt", 32'({if_gnt, ma_gnt, dbg_gnt, mem_en}), 32'd0);
            tick();
        end
        check_val("idle_mp0", 32'(mp), 32'd0);

        // 2: IF + MA reads at mp=0
        if_req = 1'b1; if_addr = 16'h0010; ma_req = 1'b1; ma_addr = 16'h0020;
        #1;
        check_val("t2_gnt", 32'({if_gnt, ma_gnt, dbg_gnt}), 32'b110);
        check_val("t2_en", 32'(mem_en), 32'b11);
        check_val("t2_we", 32'(mem_we), 32'b00);
        check_val("t2_addr1", 32'(mem_addr1), 32'h20);
        check_val("t2_addr0", 32'(mem_addr0), 32'h10);
        exp_q.push_back(port_data(~exp_mp));
        exp_q.push_back(port_data(exp_mp));
        tick(); clear_reqs(); #1;
        check_rsp("t2_ma", ma_rvalid, ma_rdata);
        check_rsp("t2_if", if_rvalid, if_rdata);
        check_val("t2_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        tick();
        check_val("t2_one_shot", 32'({if_rvalid, ma_rvalid}), 32'd0);
        check_val("t2_rdata_zero", ma_rdata, 32'd0);

        // 3: MA write vs IF read on same address
        check_val("t3_mp", 32'(mp), 32'd0);
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 16'h0040; ma_wdata = 32'hDEAD_BEEF;
        if_req = 1'b1; if_addr = 16'h0040;
        #1;
        check_val("t3_gnt", 32'({if_gnt, ma_gnt}), 32'b01);
        check_val("t3_en", 32'(mem_en), 32'b10);
        check_val("t3_we", 32'(mem_we), 32'b10);
        check_val("t3_wdata1", mem_wdata1, 32'hDEAD_BEEF);
        tick(); ma_req = 1'b0; ma_we = 1'b0; #1;
        check_val("t3_retry_gnt", 32'(if_gnt), 32'd1);
        check_val("t3_retry_en", 32'(mem_en), 32'b10);
        check_val("t3_retry_addr1", 32'(mem_addr1), 32'h40);
        check_val("t3_no_wr_rvalid", 32'(ma_rvalid), 32'd0);
        exp_q.push_back(port_data(exp_mp));
        tick(); clear_reqs(); #1;
        check_rsp("t3_if", if_rvalid, if_rdata);

        // 4: DBG starvation and forced grant
        if_req = 1'b1; if_addr = 16'h0010; ma_req = 1'b1; ma_addr = 16'h0020;
        dbg_req = 1'b1; dbg_addr = 16'h0030;
        #1;
        for (int i = 0; i < 8; i++) begin
            check_val("t4_denied", 32'(dbg_gnt), 32'd0);
            check_val("t4_cnt", 32'(starve_cnt), 32'(i));
            tick();
        end
        check_val("t4_cnt_sat", 32'(starve_cnt), 32'd8);
        check_val("t4_force_gnt", 32'({if_gnt, ma_gnt, dbg_gnt}), 32'b011);
        check_val("t4_force_addr", 32'(exp_mp ? mem_addr1 : mem_addr0), 32'h30);
        exp_q.push_back(port_data(exp_mp));
        exp_q.push_back(port_data(~exp_mp));
        tick(); clear_reqs(); #1;
        check_val("t4_cnt_clr", 32'(starve_cnt), 32'd0);
        check_rsp("t4_dbg", dbg_rvalid, dbg_rdata);
        check_rsp("t4_ma", ma_rvalid, ma_rdata);

        // 5: MA idle, IF on po and DBG on pm together
        if_req = 1'b1; if_addr = 16'h0060; dbg_req = 1'b1; dbg_addr = 16'h0050;
        #1;
        check_val("t5_gnt", 32'({if_gnt, ma_gnt, dbg_gnt}), 32'b101);
        check_val("t5_po_addr", 32'(exp_mp ? mem_addr1 : mem_addr0), 32'h60);
        check_val("t5_pm_addr", 32'(exp_mp ? mem_addr0 : mem_addr1), 32'h50);
        exp_q.push_back(port_data(exp_mp));
        exp_q.push_back(port_data(~exp_mp));
        tick(); clear_reqs(); #1;
        check_rsp("t5_if", if_rvalid, if_rdata);
        check_rsp("t5_dbg", dbg_rvalid, dbg_rdata);

        // MA write vs DBG write on same address: MA wins
        ma_req = 1'b1; ma_we = 1'b1; ma_addr = 16'h0070; ma_wdata = 32'h1111_2222;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0070; dbg_wdata = 32'h3333_4444;
        #1;
        check_val("ww_gnt", 32'({ma_gnt, dbg_gnt}), 32'b10);
        check_val("ww_we", 32'(mem_we), exp_mp ? 32'b01 : 32'b10);
        tick(); clear_reqs(); #1;
        check_val("ww_no_rvalid", 32'({ma_rvalid, dbg_rvalid}), 32'd0);

        // 6: reset one cycle after an MA read grant
        ma_req = 1'b1; ma_addr = 16'h0080;
        #1;
        check_val("t6_gnt", 32'(ma_gnt), 32'd1);
        tick();
        iw_rst = 1'b1; exp_mp = 1'b0;
        #1;
        check_val("t6_ma_rvalid", 32'(ma_rvalid), 32'd0);
        check_val("t6_ma_rdata", ma_rdata, 32'd0);
        check_val("t6_gnt_forced", 32'({if_gnt, ma_gnt, dbg_gnt}), 32'd0);
        check_val("t6_en", 32'({mem_en, mem_we}), 32'd0);
        check_val("t6_mp", 32'(mp), 32'd0);
        check_val("t6_addr", 32'(mem_addr1 | mem_addr0), 32'd0);
        tick();
        check_val("t6_still_none", 32'(ma_rvalid), 32'd0);
        check_val("q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
